// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program memory loader.
package prog_loader_pkg;

    localparam int unsigned IW_DEF = 12;
    localparam int unsigned AW_DEF = 8;

    // A LEN byte of zero requests a full 2**AW-instruction frame.
    localparam bit LEN_ZERO_MEANS_MAX = 1'b1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLen  = 3'd1,
        StHi   = 3'd2,
        StLo   = 3'd3,
        StWr   = 3'd4,
        StChk  = 3'd5,
        StDone = 3'd6,
        StErr  = 3'd7
    } state_e;

    // Bits of the HI byte that lie above the instruction word and must be zero.
    function automatic logic [7:0] hi_mask(input int unsigned iw);
        return 8'(8'hFF << (iw - 8));
    endfunction

    localparam logic [7:0] HI_MASK = hi_mask(IW_DEF);

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in and program memory write port out, bundled for the loader.
interface prog_loader_if #(
    parameter int unsigned IW = 12,
    parameter int unsigned AW = 8
);
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic [AW-1:0] Load_addr;
    logic [IW-1:0] Iin;
    logic          le;
    logic          e;

    // Host side: sources bytes, observes memory writes.
    modport master (
        output byte_in, byte_valid,
        input  byte_ready, Load_addr, Iin, le, e
    );

    // Loader side.
    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, Load_addr, Iin, le, e
    );
endinterface

// File: rtl/prog_loader.sv
// Assembles LEN / N x (HI, LO) / CHK byte frames into instruction writes.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned IW = IW_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    prog_loader_if.slave  bus,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [7:0] HiMask = hi_mask(IW);

    state_e        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [IW-1:0] iin_q, iin_d;
    logic [7:0]    chk_q, chk_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          xfer;

    assign xfer = bus.byte_valid & bus.byte_ready;

    // Output decode from the current state.
    always_comb begin
        bus.byte_ready = 1'b0;
        bus.le         = 1'b0;
        busy           = 1'b0;
        unique case (state_q)
            StLen, StHi, StLo, StChk: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
            end
            StWr: begin
                bus.le = 1'b1;
                busy   = 1'b1;
            end
            default: ;
        endcase
        bus.e         = busy;
        bus.Load_addr = addr_q;
        bus.Iin       = iin_q;
        done          = done_q;
        err           = err_q;
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        iin_d   = iin_q;
        chk_d   = chk_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StLen;
                    chk_d   = '0;
                    addr_d  = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            StLen: begin
                if (xfer) begin
                    if (LEN_ZERO_MEANS_MAX && bus.byte_in == 8'h00) begin
                        cnt_d     = '0;
                        cnt_d[AW] = 1'b1;
                    end else begin
                        cnt_d = (AW + 1)'(bus.byte_in);
                    end
                    chk_d   = chk_q ^ bus.byte_in;
                    state_d = StHi;
                end
            end
            StHi: begin
                if (xfer) begin
                    chk_d = chk_q ^ bus.byte_in;
                    if ((bus.byte_in & HiMask) != 8'h00) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end else begin
                        iin_d[IW-1:8] = bus.byte_in[IW-9:0];
                        state_d       = StLo;
                    end
                end
            end
            StLo: begin
                if (xfer) begin
                    iin_d[7:0] = bus.byte_in;
                    chk_d      = chk_q ^ bus.byte_in;
                    state_d    = StWr;
                end
            end
            StWr: begin
                // Address wraps after the last word of a full frame; it is unused then.
                addr_d  = addr_q + 1'b1;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == (AW + 1)'(1)) ? StChk : StHi;
            end
            StChk: begin
                if (xfer) begin
                    if (bus.byte_in == chk_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            iin_q   <= '0;
            chk_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            iin_q   <= iin_d;
            chk_q   <= chk_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued at stimulus, checked on le.
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, done, err;

    prog_loader_if #(.IW(12), .AW(8)) bus ();

    prog_loader dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          le_cnt = 0;
    logic [19:0] exp_q[$];
    logic [11:0] mem[256];
    logic [7:0]  hi_b[256];
    logic [7:0]  lo_b[256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Monitor: every le pulse is one memory write, compared against the queue head.
    always @(negedge clk) begin : monitor
        logic [19:0] got;
        logic [19:0] want;
        if (rst === 1'b0 && bus.le === 1'b1) begin
            le_cnt++;
            got = {bus.Load_addr, bus.Iin};
            mem[bus.Load_addr] = bus.Iin;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                         bus.Load_addr, bus.Iin);
            end else begin
                want = exp_q.pop_front();
                check("write_addr_data", 32'(got), 32'(want));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the byte was transferred.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
        int t;
        for (int k = 0; k < gap; k++) begin
            bus.byte_valid = 1'b0;
            if (poke && k == 0 && busy) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        t = 0;
        while (bus.byte_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: byte 0x%0h got no ready, expected ready", b);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [7:0] len_b, input logic [7:0] chk_flip,
                              input bit do_start, input bit gaps);
        logic [7:0] c;
        if (do_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < n; i++) exp_q.push_back({8'(i), hi_b[i][3:0], lo_b[i]});
        c = len_b;
        send_byte(len_b, gaps ? int'($urandom_range(0, 3)) : 0, gaps);
        for (int i = 0; i < n; i++) begin
            c ^= hi_b[i];
            send_byte(hi_b[i], gaps ? int'($urandom_range(0, 3)) : 0, gaps);
            c ^= lo_b[i];
            send_byte(lo_b[i], gaps ? int'($urandom_range(0, 3)) : 0, gaps);
        end
        send_byte(c ^ chk_flip, gaps ? int'($urandom_range(0, 3)) : 0, gaps);
    endtask

    task automatic load_frame_a();
        hi_b[0] = 8'h01; lo_b[0] = 8'h23;
        hi_b[1] = 8'h0A; lo_b[1] = 8'hBC;
    endtask

    initial begin
        int le0;
        int bad;
        rst = 1'b1;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({bus.byte_ready, bus.le, bus.e, busy, done, err,
                                    bus.Load_addr, bus.Iin}), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", 32'({bus.byte_ready, bus.le, bus.e, busy, done, err}), 32'h0);

        // Two-word frame; checksum 02^01^23^0A^BC = 96.
        load_frame_a();
        le0 = le_cnt;
        send_frame(2, 8'h02, 8'h00, 1'b1, 1'b0);
        check("a_done_busy_err", 32'({done, busy, err}), 32'b100);
        check("a_le_pulses", 32'(le_cnt - le0), 32'd2);
        check("a_mem0", 32'(mem[0]), 32'h123);
        check("a_mem1", 32'(mem[1]), 32'hABC);

        // Reset after one instruction of a three-word frame.
        exp_q.push_back({8'h00, 12'h456});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h03, 0, 1'b0);
        send_byte(8'h04, 0, 1'b0);
        send_byte(8'h56, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_outputs", 32'({bus.byte_ready, bus.le, bus.e, busy, done, err,
                                       bus.Load_addr, bus.Iin}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_mem0", 32'(mem[0]), 32'h456);
        hi_b[0] = 8'h07; lo_b[0] = 8'h89;
        send_frame(1, 8'h01, 8'h00, 1'b1, 1'b0);
        check("reload_done_err", 32'({done, err}), 32'b10);
        check("reload_mem0", 32'(mem[0]), 32'h789);
        check("reload_mem1_kept", 32'(mem[1]), 32'hABC);

        // Full 256-word frame, data equals address.
        for (int i = 0; i < 256; i++) begin
            hi_b[i] = 8'h00;
            lo_b[i] = 8'(i);
        end
        le0 = le_cnt;
        send_frame(256, 8'h00, 8'h00, 1'b1, 1'b0);
        check("full_le_pulses", 32'(le_cnt - le0), 32'd256);
        check("full_done_err", 32'({done, err}), 32'b10);
        check("full_addr_wrap", 32'(bus.Load_addr), 32'h0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 12'(i)) bad++;
        check("full_mem_readback_bad", 32'(bad), 32'd0);

        // Bad HI byte: error at once, no write.
        le0 = le_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h1F, 0, 1'b0);
        check("badhi_err_ready_busy_done", 32'({err, bus.byte_ready, busy, done}), 32'b1000);
        @(negedge clk);
        check("badhi_no_le", 32'(le_cnt - le0), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("badhi_start_clears_err", 32'({err, busy}), 32'b01);

        // Bad checksum from LEN state: words still written, then err.
        hi_b[0] = 8'h05; lo_b[0] = 8'h55;
        hi_b[1] = 8'h0F; lo_b[1] = 8'hFF;
        le0 = le_cnt;
        send_frame(2, 8'h02, 8'h01, 1'b0, 1'b0);
        check("badchk_err_done", 32'({err, done}), 32'b10);
        check("badchk_le_pulses", 32'(le_cnt - le0), 32'd2);
        check("badchk_mem1", 32'(mem[1]), 32'hFFF);

        // Frame A again with random gaps and stray start pulses while busy.
        load_frame_a();
        le0 = le_cnt;
        send_frame(2, 8'h02, 8'h00, 1'b1, 1'b1);
        check("gaps_done_err", 32'({done, err, busy}), 32'b100);
        check("gaps_le_pulses", 32'(le_cnt - le0), 32'd2);
        check("gaps_mem0", 32'(mem[0]), 32'h123);
        check("gaps_mem1", 32'(mem[1]), 32'hABC);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
